// File: rtl/axi_lite_arb_pkg.sv
// Shared types and constants for the AXI4-Lite transaction arbiter.
//
// Contents:
//   arb_state_e  - transaction scheduler states
//   RESP_SLVERR  - response code the external mux returns on a timed-out transaction
package axi_lite_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        BW,
        RD,
        RW,
        DRAIN
    } arb_state_e;

    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_prio_picker.sv
// Combinational round-robin priority picker.
//
// Returns the first set bit of req_i at or after ptr_i, wrapping modulo NUM_REQ.
//
// Ports:
//   req_i   in  NUM_REQ  request vector
//   ptr_i   in  SEL_W    highest-priority index for this pick
//   valid_o out  1       at least one request is set
//   idx_o   out  SEL_W   winning index (0 when valid_o is low)
module rr_prio_picker #(
    parameter int unsigned  NUM_REQ = 4,
    localparam int unsigned SEL_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SEL_W-1:0]   ptr_i,
    output logic               valid_o,
    output logic [SEL_W-1:0]   idx_o
);

    // One extra bit so ptr + offset can exceed NUM_REQ-1 before the wrap.
    localparam int unsigned EXT_W = SEL_W + 1;

    logic [EXT_W-1:0] cand;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_i} + EXT_W'(i);
            if (cand >= EXT_W'(NUM_REQ)) begin
                cand = cand - EXT_W'(NUM_REQ);
            end
            if (!valid_o && req_i[cand[SEL_W-1:0]]) begin
                valid_o = 1'b1;
                idx_o   = cand[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/axi_lite_txn_arbiter.sv
// Transaction-level scheduler sharing one AXI4-Lite slave port between NUM_REQ requesters.
// Grants one requester at a time (round robin), then opens the AW/W/B or AR/R channel
// enables of the external mux in protocol order until the single transaction completes.
// No datapath lives here.
//
// Optional feature: define AXI_LITE_TXN_ARBITER_TIMEOUT_EN to bound the B/R wait to
// TIMEOUT_CYCLES; on expiry timeout_o pulses and the block drains the late response.
//
// Ports:
//   clk_i, rst_i                clock, synchronous active-high reset
//   req_i / write_i             per-requester request (level) and write(1)/read(0) qualifier
//   gnt_o                       one-hot grant pulse
//   sel_o                       owning requester index, valid while busy_o
//   busy_o                      transaction in flight
//   aw/w/b/ar/r_en_o            channel pass-through enables to the mux
//   aw/w/b/ar/r_hs_i            shared-side valid&ready per channel
//   done_o                      completion pulse
//   timeout_o, drain_o          timeout pulse and drain mode (0 unless feature enabled)
module axi_lite_txn_arbiter
    import axi_lite_arb_pkg::*;
#(
    parameter int unsigned  NUM_REQ        = 4,
    parameter int unsigned  TIMEOUT_CYCLES = 1024,
    localparam int unsigned SEL_W          = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] write_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [SEL_W-1:0]   sel_o,
    output logic               busy_o,
    output logic               aw_en_o,
    output logic               w_en_o,
    output logic               b_en_o,
    output logic               ar_en_o,
    output logic               r_en_o,
    input  logic               aw_hs_i,
    input  logic               w_hs_i,
    input  logic               b_hs_i,
    input  logic               ar_hs_i,
    input  logic               r_hs_i,
    output logic               done_o,
    output logic               timeout_o,
    output logic               drain_o
);

    if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("axi_lite_txn_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_e         state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               done_q, done_d;
    logic               aw_done_q, aw_done_d;
    logic               w_done_q, w_done_d;

    logic               pick_valid;
    logic [SEL_W-1:0]   pick_idx;

    rr_prio_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

`ifdef AXI_LITE_TXN_ARBITER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             expired;

    // Count value reached on the last allowed waiting cycle.
    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        gnt_d     = '0;
        done_d    = 1'b0;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
`ifdef AXI_LITE_TXN_ARBITER_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    sel_d           = pick_idx;
                    gnt_d[pick_idx] = 1'b1;
                    ptr_d           = (pick_idx == SEL_W'(NUM_REQ - 1)) ? '0
                                                                       : pick_idx + SEL_W'(1);
                    state_d         = write_i[pick_idx] ? WR : RD;
                end
            end
            WR: begin
                if (aw_hs_i) aw_done_d = 1'b1;
                if (w_hs_i)  w_done_d  = 1'b1;
                // Covers both same-cycle and staggered AW/W completion.
                if (aw_done_d && w_done_d) begin
                    state_d = BW;
`ifdef AXI_LITE_TXN_ARBITER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BW: begin
                if (b_hs_i) begin
                    done_d    = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = IDLE;
                end
`ifdef AXI_LITE_TXN_ARBITER_TIMEOUT_EN
                else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RD: begin
                if (ar_hs_i) begin
                    state_d = RW;
`ifdef AXI_LITE_TXN_ARBITER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            RW: begin
                if (r_hs_i) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
`ifdef AXI_LITE_TXN_ARBITER_TIMEOUT_EN
                else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
`ifdef AXI_LITE_TXN_ARBITER_TIMEOUT_EN
            DRAIN: begin
                // The mux already answered SLVERR; swallow the late response.
                if (b_hs_i || r_hs_i) begin
                    done_d    = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            sel_q     <= '0;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

`ifdef AXI_LITE_TXN_ARBITER_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
    assign drain_o   = (state_q == DRAIN);
`else
    assign timeout_o = 1'b0;
    assign drain_o   = 1'b0;
`endif

    // Enables decode the registered state only: no path from *_hs_i to *_en_o.
    assign gnt_o   = gnt_q;
    assign sel_o   = sel_q;
    assign done_o  = done_q;
    assign busy_o  = (state_q != IDLE);
    assign aw_en_o = (state_q == WR) && !aw_done_q;
    assign w_en_o  = (state_q == WR) && !w_done_q;
    assign b_en_o  = (state_q == BW);
    assign ar_en_o = (state_q == RD);
    assign r_en_o  = (state_q == RW);

endmodule
